// File: rtl/aha_tlx_rx_trainer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aha_tlx_rx_trainer_if : control/status bundle of the TLX RX lane trainer |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface aha_tlx_rx_trainer_if #(
  parameter int LANES = 4,
  parameter int SEQ_W = 32,
  parameter int CNT_W = 32
);
  localparam int OFS_W = $clog2(SEQ_W);

  logic [LANES-1:0]       D_IN;
  logic                   START;
  logic                   CLEAR;
  logic [SEQ_W-1:0]       SEQUENCE;
  logic [CNT_W-1:0]       LENGTH;
  logic                   AUTO_STOP;
  logic                   DONE;
  logic                   ACTIVE;
  logic [LANES-1:0]       LOCKED;
  logic [LANES*OFS_W-1:0] ALIGN_OFS;
  logic [LANES*CNT_W-1:0] MATCH_COUNT;
  logic [LANES*CNT_W-1:0] ERR_COUNT;

  modport master (
    output D_IN, START, CLEAR, SEQUENCE, LENGTH, AUTO_STOP,
    input  DONE, ACTIVE, LOCKED, ALIGN_OFS, MATCH_COUNT, ERR_COUNT
  );

  modport slave (
    input  D_IN, START, CLEAR, SEQUENCE, LENGTH, AUTO_STOP,
    output DONE, ACTIVE, LOCKED, ALIGN_OFS, MATCH_COUNT, ERR_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/aha_tlx_rx_trainer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aha_tlx_rx_trainer : per-lane word alignment search and match/err counts |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module aha_tlx_rx_trainer #(
  parameter int LANES = 4,
  parameter int SEQ_W = 32,
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  aha_tlx_rx_trainer_if.slave  tlx
);
  localparam int                 OFS_W      = $clog2(SEQ_W);
  localparam logic [OFS_W-1:0]   c_BIT_LAST = OFS_W'(SEQ_W - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t            state_q;
  logic              start_q;
  logic              clear_q;
  logic              done_q;
  logic              filled_q;
  logic [OFS_W-1:0]  bit_q;
  logic [CNT_W-1:0]  word_q;

  logic w_start_pulse;
  logic w_clear_pulse;
  logic w_at_len;
  logic w_active;
  logic w_step;
  logic w_zero;

  assign w_start_pulse = tlx.START & ~start_q;
  assign w_clear_pulse = tlx.CLEAR & ~clear_q;
  assign w_at_len      = tlx.AUTO_STOP & (word_q == tlx.LENGTH);
  assign w_active      = (state_q == ST_RUN) & ~w_at_len;
  // The terminal RUN cycle (word count reached) processes no data.
  assign w_step        = w_active & ~w_clear_pulse;
  assign w_zero        = w_clear_pulse | (w_start_pulse & (state_q == ST_IDLE));

  assign tlx.DONE   = done_q;
  assign tlx.ACTIVE = w_active;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
      filled_q <= 1'b0;
      bit_q    <= '0;
      word_q   <= '0;
    end else begin
      start_q <= tlx.START;
      clear_q <= tlx.CLEAR;
      if (w_clear_pulse) begin
        state_q  <= ST_IDLE;
        done_q   <= 1'b0;
        filled_q <= 1'b0;
        bit_q    <= '0;
        word_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (w_start_pulse) begin
              state_q  <= ST_RUN;
              filled_q <= 1'b0;
              bit_q    <= '0;
              word_q   <= '0;
            end
          end
          ST_RUN: begin
            if (w_at_len) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              bit_q <= bit_q + OFS_W'(1);
              if (bit_q == c_BIT_LAST) begin
                filled_q <= 1'b1;
                if (word_q != c_CNT_MAX) begin
                  word_q <= word_q + CNT_W'(1);
                end
              end
            end
          end
          ST_FINISH: state_q <= ST_IDLE;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [SEQ_W-1:0] sr_q,    sr_d;
    logic             lock_q,  lock_d;
    logic [OFS_W-1:0] ofs_q,   ofs_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] err_q,   err_d;
    logic             w_eq;

    assign w_eq = (sr_q == tlx.SEQUENCE);

    always_comb begin
      sr_d    = sr_q;
      lock_d  = lock_q;
      ofs_d   = ofs_q;
      match_d = match_q;
      err_d   = err_q;
      if (w_zero) begin
        sr_d    = '0;
        lock_d  = 1'b0;
        ofs_d   = '0;
        match_d = '0;
        err_d   = '0;
      end else if (w_step) begin
        sr_d = {tlx.D_IN[n], sr_q[SEQ_W-1:1]};
        // sr_q holds the last SEQ_W bits, oldest at bit 0, so bit_q is the phase.
        if (filled_q) begin
          if (!lock_q) begin
            if (w_eq) begin
              lock_d  = 1'b1;
              ofs_d   = bit_q;
              match_d = (match_q == c_CNT_MAX) ? match_q : match_q + CNT_W'(1);
            end
          end else if (bit_q == ofs_q) begin
            if (w_eq) begin
              match_d = (match_q == c_CNT_MAX) ? match_q : match_q + CNT_W'(1);
            end else begin
              err_d = (err_q == c_CNT_MAX) ? err_q : err_q + CNT_W'(1);
            end
          end
        end
      end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        sr_q    <= '0;
        lock_q  <= 1'b0;
        ofs_q   <= '0;
        match_q <= '0;
        err_q   <= '0;
      end else begin
        sr_q    <= sr_d;
        lock_q  <= lock_d;
        ofs_q   <= ofs_d;
        match_q <= match_d;
        err_q   <= err_d;
      end
    end

    assign tlx.LOCKED[n]                     = lock_q;
    assign tlx.ALIGN_OFS[n*OFS_W +: OFS_W]   = ofs_q;
    assign tlx.MATCH_COUNT[n*CNT_W +: CNT_W] = match_q;
    assign tlx.ERR_COUNT[n*CNT_W +: CNT_W]   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_aha_tlx_rx_trainer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aha_tlx_rx_trainer : randomized bench with bit-history reference model|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_aha_tlx_rx_trainer;
  localparam int LANES = 4;
  localparam int SEQ_W = 32;
  localparam int CNT_W = 32;
  localparam int OFS_W = 5;
  localparam int MAXB  = 4096;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic rst_s_n = 1'b0;

  int checks = 0;
  int passed = 0;

  bit   stream [LANES][MAXB];
  bit   e_lock [LANES];
  int   e_ofs  [LANES];
  int   e_match[LANES];
  int   e_err  [LANES];

  always #5 CLK = ~CLK;

  aha_tlx_rx_trainer_if #(.LANES(LANES), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) bus ();
  aha_tlx_rx_trainer_if #(.LANES(2), .SEQ_W(8), .CNT_W(4)) sbus ();

  aha_tlx_rx_trainer #(.LANES(LANES), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESETn(RESETn), .tlx(bus));
  aha_tlx_rx_trainer #(.LANES(2), .SEQ_W(8), .CNT_W(4)) dut_s (
    .CLK(CLK), .RESETn(rst_s_n), .tlx(sbus));

  // kind 0: repeated seq starting at bit index 'phase', word fw gets bit fb flipped
  // kind 1: all zeros, kind 2: random bits
  task automatic gen_lane(input int l, input logic [31:0] seq, input int kind,
                          input int phase, input int fw, input int fb, input int n);
    int idx;
    bit b;
    for (int i = 0; i < n; i++) begin
      idx = (((i - phase) % 32) + 32) % 32;
      case (kind)
        0: begin
          b = seq[idx];
          if (i >= phase && ((i - phase) / 32) == fw && idx == fb) b = ~b;
        end
        1: b = 1'b0;
        default: b = 1'($urandom_range(0, 1));
      endcase
      stream[l][i] = b;
    end
  endtask

  // Window m covers received bits m-32..m-1; phase of a window is m mod 32.
  task automatic model_lane(input int l, input logic [31:0] seq, input int n);
    logic [31:0] w;
    e_lock[l] = 1'b0; e_ofs[l] = 0; e_match[l] = 0; e_err[l] = 0;
    for (int m = 32; m < n; m++) begin
      for (int k = 0; k < 32; k++) w[k] = stream[l][m-32+k];
      if (!e_lock[l]) begin
        if (w == seq) begin
          e_lock[l] = 1'b1; e_ofs[l] = m % 32; e_match[l]++;
        end
      end else if ((m % 32) == e_ofs[l]) begin
        if (w == seq) e_match[l]++;
        else          e_err[l]++;
      end
    end
  endtask

  task automatic run_auto(input logic [31:0] seq, input int len, output int done_low);
    int n;
    int act_bad;
    n = 32 * len;
    act_bad = 0;
    done_low = 0;
    @(negedge CLK);
    bus.SEQUENCE = seq; bus.LENGTH = 32'(len); bus.AUTO_STOP = 1'b1; bus.START = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      bus.START = 1'b0;
      if (bus.ACTIVE !== 1'b1) act_bad++;
      if (bus.DONE !== 1'b1) done_low++;
      for (int l = 0; l < LANES; l++) bus.D_IN[l] = stream[l][j];
    end
    @(negedge CLK);
    checks++;
    if (bus.ACTIVE !== 1'b0) $display("FAIL stop_cycle_active: got %0b expected 0", bus.ACTIVE);
    else passed++;
    repeat (2) @(negedge CLK);
    checks++;
    if (act_bad !== 0) $display("FAIL active_during_run: got %0d inactive cycles expected 0", act_bad);
    else passed++;
    for (int l = 0; l < LANES; l++) model_lane(l, seq, n);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.DONE, bus.ACTIVE, bus.LOCKED, bus.ALIGN_OFS, bus.MATCH_COUNT, bus.ERR_COUNT} !== '0)
      $display("FAIL reset_outputs: got done=%0b active=%0b locked=%0h match=%0h err=%0h expected all 0",
               bus.DONE, bus.ACTIVE, bus.LOCKED, bus.MATCH_COUNT, bus.ERR_COUNT);
    else passed++;
  endtask

  task automatic test_spec_run();
    logic [31:0] seq;
    int dl;
    seq = 32'hA5A5_3C3C;
    gen_lane(0, seq, 0, 5, -1, 0, 320);
    gen_lane(1, seq, 0, 11, 3, 7, 320);
    gen_lane(2, seq, 1, 0, -1, 0, 320);
    gen_lane(3, seq, 2, 0, -1, 0, 320);
    run_auto(seq, 10, dl);
    checks++;
    if (bus.DONE !== 1'b1) $display("FAIL spec_done: got %0b expected 1", bus.DONE); else passed++;
    checks++;
    if (bus.LOCKED[0] !== 1'b1 || bus.ALIGN_OFS[4:0] !== 5'd5)
      $display("FAIL spec_lane0_lock: got lock=%0b ofs=%0d expected lock=1 ofs=5", bus.LOCKED[0], bus.ALIGN_OFS[4:0]);
    else passed++;
    checks++;
    if (bus.MATCH_COUNT[31:0] !== 32'd9 || bus.ERR_COUNT[31:0] !== 32'd0)
      $display("FAIL spec_lane0_counts: got match=%0d err=%0d expected match=9 err=0",
               bus.MATCH_COUNT[31:0], bus.ERR_COUNT[31:0]);
    else passed++;
    checks++;
    if (bus.LOCKED[1] !== 1'b1 || bus.ERR_COUNT[63:32] !== 32'd1 || bus.MATCH_COUNT[63:32] !== 32'd8)
      $display("FAIL spec_lane1_err: got lock=%0b match=%0d err=%0d expected lock=1 match=8 err=1",
               bus.LOCKED[1], bus.MATCH_COUNT[63:32], bus.ERR_COUNT[63:32]);
    else passed++;
    checks++;
    if (bus.LOCKED[2] !== 1'b0 || bus.MATCH_COUNT[95:64] !== 32'd0 || bus.ERR_COUNT[95:64] !== 32'd0)
      $display("FAIL spec_lane2_zero: got lock=%0b match=%0d err=%0d expected all 0",
               bus.LOCKED[2], bus.MATCH_COUNT[95:64], bus.ERR_COUNT[95:64]);
    else passed++;
    checks++;
    if (bus.LOCKED[3] !== e_lock[3] || bus.ALIGN_OFS[19:15] !== 5'(e_ofs[3]) ||
        bus.MATCH_COUNT[127:96] !== 32'(e_match[3]) || bus.ERR_COUNT[127:96] !== 32'(e_err[3]))
      $display("FAIL spec_lane3_model: got lock=%0b ofs=%0d match=%0d err=%0d expected lock=%0b ofs=%0d match=%0d err=%0d",
               bus.LOCKED[3], bus.ALIGN_OFS[19:15], bus.MATCH_COUNT[127:96], bus.ERR_COUNT[127:96],
               e_lock[3], e_ofs[3], e_match[3], e_err[3]);
    else passed++;
  endtask

  task automatic test_random_runs();
    logic [31:0] seq;
    int len, dl, kind;
    for (int it = 0; it < 3; it++) begin
      seq = $urandom;
      if (seq == 32'd0) seq = 32'h1;
      len = $urandom_range(2, 8);
      for (int l = 0; l < LANES; l++) begin
        kind = $urandom_range(0, 3);
        gen_lane(l, seq, (kind < 2) ? 0 : kind - 1, $urandom_range(0, 31),
                 (kind == 1) ? $urandom_range(1, len - 1) : -1, $urandom_range(0, 31), 32 * len);
      end
      run_auto(seq, len, dl);
      // results must hold while idle regardless of line activity
      repeat (5) begin
        @(negedge CLK);
        bus.D_IN = 4'($urandom);
      end
      checks++;
      if (bus.DONE !== 1'b1) $display("FAIL rand_done_%0d: got %0b expected 1", it, bus.DONE); else passed++;
      for (int l = 0; l < LANES; l++) begin
        checks++;
        if (bus.LOCKED[l] !== e_lock[l])
          $display("FAIL rand_lock_%0d_%0d: got %0b expected %0b", it, l, bus.LOCKED[l], e_lock[l]);
        else passed++;
        checks++;
        if (bus.ALIGN_OFS[l*OFS_W +: OFS_W] !== 5'(e_ofs[l]))
          $display("FAIL rand_ofs_%0d_%0d: got %0d expected %0d", it, l, bus.ALIGN_OFS[l*OFS_W +: OFS_W], e_ofs[l]);
        else passed++;
        checks++;
        if (bus.MATCH_COUNT[l*CNT_W +: CNT_W] !== 32'(e_match[l]))
          $display("FAIL rand_match_%0d_%0d: got %0d expected %0d", it, l, bus.MATCH_COUNT[l*CNT_W +: CNT_W], e_match[l]);
        else passed++;
        checks++;
        if (bus.ERR_COUNT[l*CNT_W +: CNT_W] !== 32'(e_err[l]))
          $display("FAIL rand_err_%0d_%0d: got %0d expected %0d", it, l, bus.ERR_COUNT[l*CNT_W +: CNT_W], e_err[l]);
        else passed++;
      end
    end
  endtask

  task automatic test_start_clear_same();
    int bad;
    bad = 0;
    @(negedge CLK);
    bus.START = 1'b1; bus.CLEAR = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      if (bus.ACTIVE !== 1'b0) bad++;
    end
    bus.START = 1'b0; bus.CLEAR = 1'b0;
    checks++;
    if (bad !== 0) $display("FAIL simul_active: got %0d active cycles expected 0", bad); else passed++;
    checks++;
    if ({bus.DONE, bus.LOCKED, bus.MATCH_COUNT, bus.ERR_COUNT} !== '0)
      $display("FAIL simul_cleared: got done=%0b locked=%0h match=%0h err=%0h expected all 0",
               bus.DONE, bus.LOCKED, bus.MATCH_COUNT, bus.ERR_COUNT);
    else passed++;
  endtask

  task automatic test_free_run();
    logic [31:0] seq;
    int n, bad;
    seq = $urandom | 32'h8000_0001;
    n = 3200;
    bad = 0;
    gen_lane(0, seq, 0, 0, -1, 0, n);
    for (int l = 1; l < LANES; l++) gen_lane(l, seq, 2, 0, -1, 0, n);
    @(negedge CLK);
    bus.SEQUENCE = seq; bus.LENGTH = 32'd2; bus.AUTO_STOP = 1'b0; bus.START = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      bus.START = 1'b0;
      if (bus.ACTIVE !== 1'b1 || bus.DONE !== 1'b0) bad++;
      for (int l = 0; l < LANES; l++) bus.D_IN[l] = stream[l][j];
    end
    @(negedge CLK);
    checks++;
    if (bad !== 0) $display("FAIL free_active_done: got %0d bad cycles expected 0", bad); else passed++;
    model_lane(0, seq, n);
    checks++;
    if (bus.MATCH_COUNT[31:0] !== 32'(e_match[0]) || e_match[0] != 99)
      $display("FAIL free_match0: got %0d expected 99 (model %0d)", bus.MATCH_COUNT[31:0], e_match[0]);
    else passed++;
    bus.CLEAR = 1'b1;
    @(negedge CLK);
    bus.CLEAR = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.DONE, bus.ACTIVE, bus.LOCKED, bus.ALIGN_OFS, bus.MATCH_COUNT, bus.ERR_COUNT} !== '0)
      $display("FAIL free_clear: got done=%0b active=%0b locked=%0h match=%0h err=%0h expected all 0",
               bus.DONE, bus.ACTIVE, bus.LOCKED, bus.MATCH_COUNT, bus.ERR_COUNT);
    else passed++;
  endtask

  task automatic test_zero_length();
    logic [31:0] seq;
    int dl;
    seq = 32'h1234_5678;
    @(negedge CLK);
    bus.SEQUENCE = seq; bus.LENGTH = 32'd0; bus.AUTO_STOP = 1'b1; bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    checks++;
    if (bus.ACTIVE !== 1'b0) $display("FAIL zero_len_active: got %0b expected 0", bus.ACTIVE); else passed++;
    @(negedge CLK);
    checks++;
    if (bus.DONE !== 1'b1 || {bus.LOCKED, bus.MATCH_COUNT, bus.ERR_COUNT} !== '0)
      $display("FAIL zero_len_done: got done=%0b match=%0h err=%0h expected done=1 counts 0",
               bus.DONE, bus.MATCH_COUNT, bus.ERR_COUNT);
    else passed++;
    for (int l = 0; l < LANES; l++) gen_lane(l, seq, (l == 3) ? 2 : 0, l * 7, -1, 0, 96);
    run_auto(seq, 3, dl);
    checks++;
    if (dl !== 0) $display("FAIL fresh_done_sticky: got %0d low cycles expected 0", dl); else passed++;
    for (int l = 0; l < LANES; l++) begin
      checks++;
      if (bus.LOCKED[l] !== e_lock[l] || bus.MATCH_COUNT[l*CNT_W +: CNT_W] !== 32'(e_match[l]) ||
          bus.ERR_COUNT[l*CNT_W +: CNT_W] !== 32'(e_err[l]))
        $display("FAIL fresh_lane_%0d: got lock=%0b match=%0d err=%0d expected lock=%0b match=%0d err=%0d",
                 l, bus.LOCKED[l], bus.MATCH_COUNT[l*CNT_W +: CNT_W], bus.ERR_COUNT[l*CNT_W +: CNT_W],
                 e_lock[l], e_match[l], e_err[l]);
      else passed++;
    end
    @(negedge CLK);
    bus.CLEAR = 1'b1;
    @(negedge CLK);
    bus.CLEAR = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.DONE !== 1'b0) $display("FAIL fresh_clear_done: got %0b expected 0", bus.DONE); else passed++;
  endtask

  task automatic test_saturate_reset();
    logic [7:0] s8;
    s8 = 8'hB4;
    @(negedge CLK);
    sbus.SEQUENCE = s8; sbus.LENGTH = 4'd0; sbus.AUTO_STOP = 1'b0; sbus.START = 1'b1;
    for (int j = 0; j < 168; j++) begin
      @(negedge CLK);
      sbus.START = 1'b0;
      sbus.D_IN = {1'($urandom_range(0, 1)), s8[j % 8]};
    end
    @(negedge CLK);
    checks++;
    if (sbus.LOCKED[0] !== 1'b1 || sbus.MATCH_COUNT[3:0] !== 4'd15 || sbus.ERR_COUNT[3:0] !== 4'd0)
      $display("FAIL sat_match: got lock=%0b match=%0d err=%0d expected lock=1 match=15 err=0",
               sbus.LOCKED[0], sbus.MATCH_COUNT[3:0], sbus.ERR_COUNT[3:0]);
    else passed++;
    checks++;
    if (sbus.ACTIVE !== 1'b1) $display("FAIL sat_active: got %0b expected 1", sbus.ACTIVE); else passed++;
    rst_s_n = 1'b0;
    #1;
    checks++;
    if ({sbus.DONE, sbus.ACTIVE, sbus.LOCKED, sbus.ALIGN_OFS, sbus.MATCH_COUNT, sbus.ERR_COUNT} !== '0)
      $display("FAIL async_reset: got done=%0b active=%0b locked=%0h match=%0h err=%0h expected all 0",
               sbus.DONE, sbus.ACTIVE, sbus.LOCKED, sbus.MATCH_COUNT, sbus.ERR_COUNT);
    else passed++;
    @(negedge CLK);
    rst_s_n = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (sbus.ACTIVE !== 1'b0 || sbus.MATCH_COUNT !== '0)
      $display("FAIL post_reset_idle: got active=%0b match=%0h expected 0", sbus.ACTIVE, sbus.MATCH_COUNT);
    else passed++;
  endtask

  initial begin
    bus.D_IN = '0; bus.START = 1'b0; bus.CLEAR = 1'b0;
    bus.SEQUENCE = '0; bus.LENGTH = '0; bus.AUTO_STOP = 1'b0;
    sbus.D_IN = '0; sbus.START = 1'b0; sbus.CLEAR = 1'b0;
    sbus.SEQUENCE = '0; sbus.LENGTH = '0; sbus.AUTO_STOP = 1'b0;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    rst_s_n = 1'b1;
    @(negedge CLK);
    test_reset();
    test_spec_run();
    test_random_runs();
    test_start_clear_same();
    test_free_run();
    test_zero_length();
    test_saturate_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
